sound_scheduler: RTL and testbench

SOUND_SCHEDULER -- requirements
Module: sound_scheduler

---
 rtl/sound_pkg.sv | 18 +
 rtl/sound_step_timer.sv | 20 ++
 rtl/sound_scheduler.sv | 119 +++++++++++
 tb/tb_sound_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: shared states, grant bit indices and default timing constants for the sound scheduler
package sound_pkg;
  typedef enum logic [2:0] {IDLE, ENGINE, CLICK, WARN_ON, WARN_OFF, HORN} state_t;
  localparam int G_ENGINE = 0;
  localparam int G_CLICK = 1;
  localparam int G_WARN = 2;
  localparam int G_HORN = 3;
  localparam int TW = 16;
  localparam int PW = 20;
  localparam int BW = 8;
  localparam int unsigned DEF_CLICK_MS = 3;
  localparam int unsigned DEF_WARN_ON_MS = 100;
  localparam int unsigned DEF_WARN_OFF_MS = 100;
  localparam int unsigned DEF_WARN_BEEPS = 3;
  localparam int unsigned DEF_HORN_HALF = 62500;
  localparam int unsigned DEF_CLICK_HALF = 25000;
  localparam int unsigned DEF_WARN_HALF = 20833;
endpackage

// File: rtl/sound_step_timer.sv
// sound_step_timer: loadable, freezable ms down-counter; done flags the tick that takes it from 1 to 0
module sound_step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         freeze,
  output logic         done
);
  logic [W-1:0] cnt;
  assign done = tick && !freeze && cnt == W'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && !freeze && cnt != '0) cnt <= cnt - W'(1);
  end
endmodule

// File: rtl/sound_scheduler.sv
// sound_scheduler: prioritises horn, warning chime, turn click and engine noise onto one tone generator
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned CLICK_MS = DEF_CLICK_MS,
  parameter int unsigned WARN_ON_MS = DEF_WARN_ON_MS,
  parameter int unsigned WARN_OFF_MS = DEF_WARN_OFF_MS,
  parameter int unsigned WARN_BEEPS = DEF_WARN_BEEPS,
  parameter int unsigned HORN_HALF = DEF_HORN_HALF,
  parameter int unsigned CLICK_HALF = DEF_CLICK_HALF,
  parameter int unsigned WARN_HALF = DEF_WARN_HALF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1ms,
  input  logic          horn_req,
  input  logic          click_req,
  input  logic          warn_req,
  input  logic          engine_en,
  input  logic [PW-1:0] engine_period,
  output logic [PW-1:0] tone_period,
  output logic          noise_sel,
  output logic [3:0]    grant,
  output logic          busy
);
  state_t state, ns;
  logic warn_act, act_n, warn_ph, ph_n, pend, pend_n, ld, done, freeze;
  logic [BW-1:0] beeps, beeps_n, b_eff;
  logic [TW-1:0] ld_val;
  logic [PW-1:0] tone_n;
  logic [3:0] grant_n;
  assign freeze = !(state inside {CLICK, WARN_ON, WARN_OFF}) || horn_req;
  sound_step_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(ld),
    .load_val(ld_val),
    .tick(tick_1ms),
    .freeze(freeze),
    .done(done)
  );
  always_comb begin
    ns = IDLE;
    ld = 1'b0;
    ld_val = '0;
    act_n = warn_act;
    ph_n = warn_ph;
    beeps_n = beeps;
    pend_n = pend;
    b_eff = warn_req ? BW'(WARN_BEEPS) : beeps;
    if (!warn_act && warn_req) begin
      act_n = 1'b1;
      ph_n = 1'b0;
      beeps_n = BW'(WARN_BEEPS);
      ld = 1'b1;
      ld_val = TW'(WARN_ON_MS);
    end else if (warn_act) begin
      beeps_n = b_eff;
      if (done && state == WARN_ON) begin
        ph_n = 1'b1;
        ld = 1'b1;
        ld_val = TW'(WARN_OFF_MS);
      end else if (done && state == WARN_OFF) begin
        if (b_eff == BW'(1)) act_n = 1'b0;
        else begin
          ph_n = 1'b0;
          beeps_n = b_eff - BW'(1);
          ld = 1'b1;
          ld_val = TW'(WARN_ON_MS);
        end
      end
    end
    // an aborted click under the horn is dropped; one displaced by a warning is replayed
    if (horn_req) begin
      ns = HORN;
      pend_n = pend || click_req;
    end else if (act_n) begin
      ns = ph_n ? WARN_OFF : WARN_ON;
      pend_n = pend || click_req || (state == CLICK && !done);
    end else if (click_req || pend || (state == CLICK && !done)) begin
      ns = CLICK;
      pend_n = 1'b0;
      if (state != CLICK || click_req) begin
        ld = 1'b1;
        ld_val = TW'(CLICK_MS);
      end
    end else if (engine_en && engine_period != '0) ns = ENGINE;
    tone_n = ns == HORN ? PW'(HORN_HALF) : ns == WARN_ON ? PW'(WARN_HALF) :
             ns == CLICK ? PW'(CLICK_HALF) : ns == ENGINE ? engine_period : '0;
    grant_n = '0;
    grant_n[G_HORN] = ns == HORN;
    grant_n[G_WARN] = ns inside {WARN_ON, WARN_OFF};
    grant_n[G_CLICK] = ns == CLICK;
    grant_n[G_ENGINE] = ns == ENGINE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      warn_act <= 1'b0;
      warn_ph <= 1'b0;
      beeps <= '0;
      pend <= 1'b0;
      tone_period <= '0;
      noise_sel <= 1'b0;
      grant <= '0;
      busy <= 1'b0;
    end else begin
      state <= ns;
      warn_act <= act_n;
      warn_ph <= ph_n;
      beeps <= beeps_n;
      pend <= pend_n;
      tone_period <= tone_n;
      noise_sel <= ns == ENGINE;
      grant <= grant_n;
      busy <= ns == CLICK || act_n || pend_n;
    end
  end
endmodule

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler: directed vector table plus hand sequences for warning, horn preemption and reset
module tb_sound_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_1ms = 1'b0;
  logic horn_req = 1'b0;
  logic click_req = 1'b0;
  logic warn_req = 1'b0;
  logic engine_en = 1'b0;
  logic [19:0] engine_period = '0;
  logic [19:0] tone_period;
  logic noise_sel;
  logic [3:0] grant;
  logic busy;
  int total = 0;
  int passed = 0;

  typedef struct {
    logic h, c, w, en;
    logic [19:0] per;
    logic t;
    logic [19:0] tone;
    logic nz;
    logic [3:0] g;
    logic b;
  } vec_t;
  vec_t vt[$];

  sound_scheduler dut (
    .clk(clk),
    .rst(rst),
    .tick_1ms(tick_1ms),
    .horn_req(horn_req),
    .click_req(click_req),
    .warn_req(warn_req),
    .engine_en(engine_en),
    .engine_period(engine_period),
    .tone_period(tone_period),
    .noise_sel(noise_sel),
    .grant(grant),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic h, c, w, en, logic [19:0] per, logic t,
                              logic [19:0] tone, logic nz, logic [3:0] g, logic b);
    mk = '{h, c, w, en, per, t, tone, nz, g, b};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      tick_1ms = 1'b1;
      cyc();
      tick_1ms = 1'b0;
      cyc();
    end
  endtask

  task automatic chk(input string name, input logic [19:0] tone, input logic nz,
                     input logic [3:0] g, input logic b);
    total++;
    if (tone_period === tone && noise_sel === nz && grant === g && busy === b) passed++;
    else $display("FAIL %s: got tone=%0d noise=%0b grant=%b busy=%0b, want tone=%0d noise=%0b grant=%b busy=%0b",
                  name, tone_period, noise_sel, grant, busy, tone, nz, g, b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {horn_req, click_req, warn_req, tick_1ms, engine_en} = '0;
    engine_period = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    vt.push_back(mk(0,0,0,0,0,0,      0,0,4'b0000,0));
    vt.push_back(mk(0,0,0,1,120000,0, 120000,1,4'b0001,0));
    vt.push_back(mk(0,0,0,1,90000,0,  90000,1,4'b0001,0));
    vt.push_back(mk(0,1,0,1,90000,0,  25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,1,90000,1,  25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,1,90000,1,  25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,1,90000,1,  90000,1,4'b0001,0));
    vt.push_back(mk(0,0,0,0,90000,0,  0,0,4'b0000,0));
    vt.push_back(mk(0,1,0,0,0,0,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      25000,0,4'b0010,1));
    vt.push_back(mk(0,1,0,0,0,0,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      0,0,4'b0000,0));
    vt.push_back(mk(1,0,0,0,0,0,      62500,0,4'b1000,0));
    vt.push_back(mk(1,1,0,0,0,0,      62500,0,4'b1000,1));
    vt.push_back(mk(0,0,0,0,0,0,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,0,0,1,      0,0,4'b0000,0));
    vt.push_back(mk(1,0,0,1,90000,0,  62500,0,4'b1000,0));
    vt.push_back(mk(0,0,0,1,0,0,      0,0,4'b0000,0));
    vt.push_back(mk(1,1,0,1,90000,1,  62500,0,4'b1000,1));
    vt.push_back(mk(0,0,0,1,90000,0,  25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,1,90000,1,  25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,1,90000,1,  25000,0,4'b0010,1));
    vt.push_back(mk(0,0,0,1,90000,1,  90000,1,4'b0001,0));
    vt.push_back(mk(0,1,0,1,90000,0,  25000,0,4'b0010,1));
    vt.push_back(mk(1,0,0,1,90000,0,  62500,0,4'b1000,0));
    vt.push_back(mk(0,0,0,1,90000,0,  90000,1,4'b0001,0));

    do_reset();
    chk("reset", 0, 0, 4'b0000, 0);
    foreach (vt[i]) begin
      {horn_req, click_req, warn_req, engine_en} = {vt[i].h, vt[i].c, vt[i].w, vt[i].en};
      engine_period = vt[i].per;
      tick_1ms = vt[i].t;
      cyc();
      chk($sformatf("vec%0d", i), vt[i].tone, vt[i].nz, vt[i].g, vt[i].b);
    end

    do_reset();
    warn_req = 1'b1;
    cyc();
    warn_req = 1'b0;
    chk("warn_start", 20833, 0, 4'b0100, 1);
    for (int b = 0; b < 3; b++) begin
      run_ticks(99);
      chk($sformatf("warn_on_end%0d", b), 20833, 0, 4'b0100, 1);
      run_ticks(1);
      chk($sformatf("warn_off_start%0d", b), 0, 0, 4'b0100, 1);
      run_ticks(99);
      chk($sformatf("warn_off_end%0d", b), 0, 0, 4'b0100, 1);
      run_ticks(1);
      if (b < 2) chk($sformatf("warn_next_on%0d", b), 20833, 0, 4'b0100, 1);
      else chk("warn_done", 0, 0, 4'b0000, 0);
    end

    do_reset();
    warn_req = 1'b1;
    cyc();
    warn_req = 1'b0;
    run_ticks(200);
    chk("beep2_on", 20833, 0, 4'b0100, 1);
    run_ticks(50);
    horn_req = 1'b1;
    cyc();
    chk("horn_preempt", 62500, 0, 4'b1000, 1);
    run_ticks(30);
    chk("horn_held", 62500, 0, 4'b1000, 1);
    horn_req = 1'b0;
    cyc();
    chk("warn_resume", 20833, 0, 4'b0100, 1);
    run_ticks(49);
    chk("resume_on_end", 20833, 0, 4'b0100, 1);
    run_ticks(1);
    chk("resume_off", 0, 0, 4'b0100, 1);
    run_ticks(299);
    chk("resume_last_off", 0, 0, 4'b0100, 1);
    run_ticks(1);
    chk("resume_done", 0, 0, 4'b0000, 0);

    do_reset();
    engine_en = 1'b1;
    engine_period = 20'd120000;
    warn_req = 1'b1;
    click_req = 1'b1;
    cyc();
    {warn_req, click_req} = '0;
    chk("both_warn_first", 20833, 0, 4'b0100, 1);
    run_ticks(599);
    chk("both_warn_last", 0, 0, 4'b0100, 1);
    run_ticks(1);
    chk("both_click", 25000, 0, 4'b0010, 1);
    run_ticks(2);
    chk("both_click_end", 25000, 0, 4'b0010, 1);
    run_ticks(1);
    chk("both_engine", 120000, 1, 4'b0001, 0);

    do_reset();
    warn_req = 1'b1;
    cyc();
    warn_req = 1'b0;
    run_ticks(10);
    chk("pre_rst_warn", 20833, 0, 4'b0100, 1);
    rst = 1'b1;
    warn_req = 1'b1;
    click_req = 1'b1;
    cyc();
    chk("rst_mid_warn", 0, 0, 4'b0000, 0);
    {rst, warn_req, click_req} = '0;
    cyc();
    chk("rst_req_dropped", 0, 0, 4'b0000, 0);
    run_ticks(200);
    chk("no_resume", 0, 0, 4'b0000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
